// File: rtl/data_ram.sv
// Byte-addressable, word-organised data memory with byte/half/word access,
// sub-word sign/zero extension, fault detection and a req/ready handshake.
module data_ram #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 0,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [1:0]            size,
    input  logic                  unsigned_ld,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ready,
    output logic                  err
);

    localparam int DEPTH = 1 << (ADDR_WIDTH - 2);
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    if (DATA_WIDTH != 32) begin : g_bad_data_width
        $error("data_ram: DATA_WIDTH must be 32");
    end
    if (ADDR_WIDTH < 3) begin : g_bad_addr_width
        $error("data_ram: ADDR_WIDTH must be at least 3");
    end
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
        $error("data_ram: WAIT_STATES must be in 0..15");
    end

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state;
    logic [3:0]            cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic                  fault_q;

    logic [31:0]           mem [DEPTH];

    logic                  fault_now;
    logic                  wr_en;
    logic [3:0]            be;
    logic [31:0]           wlanes;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic                  cur_we;
    logic [1:0]            cur_size;
    logic                  cur_uns;
    logic                  cur_fault;
    logic [31:0]           word;
    logic [31:0]           shifted;
    logic [31:0]           load_val;

    // Fault and lane decode act on the live inputs: stores commit at acceptance.
    always_comb begin
        fault_now = 1'b0;
        be        = 4'b0000;
        wlanes    = wdata;
        case (size)
            2'b00: begin
                be     = 4'b0001 << addr[1:0];
                wlanes = {4{wdata[7:0]}};
            end
            2'b01: begin
                fault_now = addr[0];
                be        = addr[1] ? 4'b1100 : 4'b0011;
                wlanes    = {2{wdata[15:0]}};
            end
            2'b10: begin
                fault_now = (addr[1:0] != 2'b00);
                be        = 4'b1111;
            end
            default: fault_now = 1'b1;
        endcase
        wr_en = rst_n && (state == IDLE) && req && we && !fault_now;
    end

    // NOTE: the array has no reset branch; clearing a RAM on reset would turn it into flops.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr[ADDR_WIDTH-1:2]][8*i +: 8] <= wlanes[8*i +: 8];
            end
        end
    end

    // With no wait states RESP is entered straight from IDLE, before the capture registers are valid.
    always_comb begin
        cur_addr  = (state == IDLE) ? addr        : addr_q;
        cur_we    = (state == IDLE) ? we          : we_q;
        cur_size  = (state == IDLE) ? size        : size_q;
        cur_uns   = (state == IDLE) ? unsigned_ld : uns_q;
        cur_fault = (state == IDLE) ? fault_now   : fault_q;
        word      = mem[cur_addr[ADDR_WIDTH-1:2]];
        shifted   = word >> {cur_addr[1:0], 3'b000};
        case (cur_size)
            2'b00:   load_val = {{24{~cur_uns & shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = {{16{~cur_uns & shifted[15]}}, shifted[15:0]};
            default: load_val = word;
        endcase
        if (cur_we || cur_fault) load_val = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            ready <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
            cnt   <= 4'd0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q  <= addr;
                        we_q    <= we;
                        size_q  <= size;
                        uns_q   <= unsigned_ld;
                        fault_q <= fault_now;
                        if (WAIT_STATES > 0) begin
                            state <= WAIT;
                            cnt   <= WAIT_INIT;
                        end else begin
                            state <= RESP;
                            ready <= 1'b1;
                            err   <= fault_now;
                            rdata <= load_val;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                        ready <= 1'b1;
                        err   <= fault_q;
                        rdata <= load_val;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_ram.sv
// Self-checking bench for data_ram: a zero-wait instance for the access table
// and a three-wait instance for handshake and mid-operation reset sequences.
module tb_data_ram;

    typedef struct {
        logic        we;
        logic [9:0]  addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0 = 1'b0, req3 = 1'b0;
    logic        we = 1'b0;
    logic [9:0]  addr = '0;
    logic [1:0]  size = 2'b10;
    logic        unsigned_ld = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata0, rdata3;
    logic        ready0, ready3, err0, err3;

    int   n_vec  = 0;
    int   n_miss = 0;
    exp_t sb[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    data_ram #(.ADDR_WIDTH(10), .WAIT_STATES(0), .DATA_WIDTH(32)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .we(we), .addr(addr), .size(size),
        .unsigned_ld(unsigned_ld), .wdata(wdata), .rdata(rdata0), .ready(ready0), .err(err0)
    );

    data_ram #(.ADDR_WIDTH(10), .WAIT_STATES(3), .DATA_WIDTH(32)) dut3 (
        .clk(clk), .rst_n(rst_n), .req(req3), .we(we), .addr(addr), .size(size),
        .unsigned_ld(unsigned_ld), .wdata(wdata), .rdata(rdata3), .ready(ready3), .err(err3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [9:0] a, input logic [1:0] s,
                                input logic u, input logic [31:0] wd,
                                input logic [31:0] er, input logic ee);
        vec_t v;
        v.we = w; v.addr = a; v.size = s; v.uns = u; v.wdata = wd;
        v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    // One complete access on the chosen instance, scoreboarded and latency-checked.
    task automatic access(input bit slow, input vec_t v);
        int          lat;
        int          ws;
        logic        rdy;
        logic [31:0] held;
        exp_t        e;
        ws = slow ? 3 : 0;
        @(negedge clk);
        we = v.we; addr = v.addr; size = v.size; unsigned_ld = v.uns; wdata = v.wdata;
        if (slow) req3 = 1'b1; else req0 = 1'b1;
        sb.push_back('{rdata: v.exp_rdata, err: v.exp_err});
        @(posedge clk);
        @(negedge clk);
        req0 = 1'b0; req3 = 1'b0;
        lat = 1;
        rdy = slow ? ready3 : ready0;
        while (!rdy && lat < 40) begin
            @(negedge clk);
            lat++;
            rdy = slow ? ready3 : ready0;
        end
        e = sb.pop_front();
        if (!rdy) begin
            check("ready_timeout", 32'd0, 32'd1);
        end else begin
            check($sformatf("rdata@%h", v.addr), slow ? rdata3 : rdata0, e.rdata);
            check($sformatf("err@%h", v.addr), {31'd0, slow ? err3 : err0}, {31'd0, e.err});
            check("latency", 32'(lat), 32'(1 + ws));
            held = slow ? rdata3 : rdata0;
            @(negedge clk);
            check("ready_one_cycle", {31'd0, slow ? ready3 : ready0}, 32'd0);
            check("err_clears", {31'd0, slow ? err3 : err0}, 32'd0);
            check("rdata_holds", slow ? rdata3 : rdata0, held);
        end
    endtask

    initial begin
        vecs.push_back(mk(1, 10'h010, 2'b10, 0, 32'hDEADBEEF, 32'h0, 0));
        vecs.push_back(mk(0, 10'h010, 2'b10, 0, 32'h0, 32'hDEADBEEF, 0));
        vecs.push_back(mk(1, 10'h020, 2'b10, 0, 32'h00000000, 32'h0, 0));
        vecs.push_back(mk(1, 10'h022, 2'b00, 0, 32'hAAAAAA80, 32'h0, 0));
        vecs.push_back(mk(0, 10'h022, 2'b00, 0, 32'h0, 32'hFFFFFF80, 0));
        vecs.push_back(mk(0, 10'h022, 2'b00, 1, 32'h0, 32'h00000080, 0));
        vecs.push_back(mk(0, 10'h020, 2'b10, 0, 32'h0, 32'h00800000, 0));
        vecs.push_back(mk(1, 10'h030, 2'b10, 0, 32'h11111111, 32'h0, 0));
        vecs.push_back(mk(1, 10'h032, 2'b01, 0, 32'h55558001, 32'h0, 0));
        vecs.push_back(mk(0, 10'h030, 2'b10, 0, 32'h0, 32'h80011111, 0));
        vecs.push_back(mk(0, 10'h032, 2'b01, 0, 32'h0, 32'hFFFF8001, 0));
        vecs.push_back(mk(0, 10'h032, 2'b01, 1, 32'h0, 32'h00008001, 0));
        vecs.push_back(mk(1, 10'h040, 2'b10, 0, 32'h12345678, 32'h0, 0));
        vecs.push_back(mk(0, 10'h040, 2'b10, 0, 32'h0, 32'h12345678, 0));
        vecs.push_back(mk(1, 10'h041, 2'b10, 0, 32'hFFFFFFFF, 32'h0, 1));
        vecs.push_back(mk(0, 10'h040, 2'b10, 0, 32'h0, 32'h12345678, 0));
        vecs.push_back(mk(1, 10'h043, 2'b01, 0, 32'hFFFFFFFF, 32'h0, 1));
        vecs.push_back(mk(0, 10'h041, 2'b01, 0, 32'h0, 32'h0, 1));
        vecs.push_back(mk(0, 10'h040, 2'b11, 0, 32'h0, 32'h0, 1));
        vecs.push_back(mk(1, 10'h040, 2'b11, 0, 32'hFFFFFFFF, 32'h0, 1));
        vecs.push_back(mk(0, 10'h040, 2'b10, 0, 32'h0, 32'h12345678, 0));
        vecs.push_back(mk(0, 10'h010, 2'b10, 1, 32'h0, 32'hDEADBEEF, 0));
        vecs.push_back(mk(0, 10'h013, 2'b00, 0, 32'h0, 32'hFFFFFFDE, 0));
        vecs.push_back(mk(0, 10'h011, 2'b00, 1, 32'h0, 32'h000000BE, 0));
        vecs.push_back(mk(0, 10'h010, 2'b01, 0, 32'h0, 32'hFFFFBEEF, 0));
        vecs.push_back(mk(1, 10'h3FC, 2'b10, 0, 32'hA5A55A5A, 32'h0, 0));
        vecs.push_back(mk(0, 10'h3FF, 2'b00, 1, 32'h0, 32'h000000A5, 0));
        vecs.push_back(mk(0, 10'h3FC, 2'b01, 0, 32'h0, 32'h00005A5A, 0));

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready0", {31'd0, ready0}, 32'd0);
        check("rst_err0", {31'd0, err0}, 32'd0);
        check("rst_rdata0", rdata0, 32'd0);
        check("rst_ready3", {31'd0, ready3}, 32'd0);
        check("rst_rdata3", rdata3, 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) access(1'b0, vecs[i]);

        // Wait-state instance: prime a word, then hold req high across three accesses.
        access(1'b1, mk(1, 10'h060, 2'b10, 0, 32'h0BADBEEF, 32'h0, 0));
        access(1'b1, mk(0, 10'h060, 2'b10, 0, 32'h0, 32'h0BADBEEF, 0));
        @(negedge clk);
        we = 1'b0; addr = 10'h060; size = 2'b10; unsigned_ld = 1'b0;
        req3 = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            check($sformatf("held_req_ready_%0d", i), {31'd0, ready3}, {31'd0, (i % 5) == 4});
            if ((i % 5) == 4) check("held_req_rdata", rdata3, 32'h0BADBEEF);
        end
        req3 = 1'b0;

        // Reset during WAIT drops the response but keeps the committed store.
        @(negedge clk);
        we = 1'b1; addr = 10'h050; size = 2'b10; wdata = 32'hCAFEF00D;
        req3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req3 = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_ready", {31'd0, ready3}, 32'd0);
        check("midrst_err", {31'd0, err3}, 32'd0);
        check("midrst_rdata", rdata3, 32'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midrst_no_ready", {31'd0, ready3}, 32'd0);
        end
        access(1'b1, mk(0, 10'h050, 2'b10, 0, 32'h0, 32'hCAFEF00D, 0));
        access(1'b0, mk(0, 10'h020, 2'b10, 0, 32'h0, 32'h00800000, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/data_ram.md
Name: data_ram

Overview:
- Byte-addressable, word-organised data memory for the CPU load/store path.
- Parametrised successor of the plain word RAM:
  - supports byte, half and word accesses with byte-lane writes;
  - sign- or zero-extends sub-word loads;
  - flags misaligned or reserved-size accesses;
  - uses a req/ready handshake with configurable wait states, so slower memory timing can be modelled without changing the core.

Parameters:
- ADDR_WIDTH, 10: byte-address width. Depth is 1<<(ADDR_WIDTH-2) 32-bit words. Legal range is ≥3.
- WAIT_STATES, 0: extra cycles inserted between acceptance and response. Legal range is 0..15.
- DATA_WIDTH, 32: data bus width. Fixed at 32; any other value is a elaboration error.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  synchronous, active-low reset.
- req  input  1  access request, sampled only in IDLE.
- we  input  1  1 = store, 0 = load.
- addr  input  ADDR_WIDTH  byte address.
- size  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- unsigned_ld  input  1  1 = zero-extend sub-word load, 0 = sign-extend.
- wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rdata  output  32  load result, right-aligned and extended.
- ready  output  1  one-cycle response strobe.
- err  output  1  access fault; valid only while ready=1.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low, on rst_n.
- Reset (rst_n=0 at posedge):
  - state←IDLE, ready←0, err←0, rdata←0, wait counter←0.
  - Memory contents are not reset.
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - If req=1, the access is accepted at this edge.
  - addr, we, size and unsigned_ld are captured.
  - Next state is WAIT if WAIT_STATES>0 (counter←WAIT_STATES-1), otherwise RESP.
- WAIT:
  - Counter decrements each cycle.
  - When counter=0, next state is RESP.
- RESP:
  - ready=1 for exactly one cycle, then the FSM returns to IDLE.
- req is ignored in WAIT and RESP and is not queued.
- Timing:
  - Accept at edge T gives ready high in cycle T+1+WAIT_STATES.
  - Maximum throughput is one access per 2+WAIT_STATES cycles.
- Fault detection (evaluated at acceptance), fault if any of:
  - size=11;
  - size=01 with addr[0]=1;
  - size=10 with addr[1:0]≠00.
- On a faulted access:
  - No memory write.
  - In the RESP cycle: err=1, rdata=0.
  - Latency is unchanged.
- Store commit:
  - Happens at the acceptance edge.
  - Word index is addr[ADDR_WIDTH-1:2].
  - byte: lane addr[1:0] ← wdata[7:0].
  - half: lanes {addr[1],1},{addr[1],0} ← wdata[15:0].
  - word: all lanes ← wdata.
  - Unselected lanes are unchanged.
- Store response: rdata=0 in the RESP cycle.
- Load:
  - The word is read at the edge entering RESP.
  - The selected lane(s) are shifted to bit 0.
  - Upper bits are filled with the sign bit when unsigned_ld=0, zeros when unsigned_ld=1.
  - unsigned_ld is ignored for word loads.
  - The result is registered into rdata, so it is valid in the RESP cycle.
- rdata holds its value after RESP until the next RESP or reset.
- err returns to 0 when ready deasserts.
- Read-after-write: a load accepted after a store's RESP sees the stored data.
- No in-flight overlap is possible.
- Reset mid-operation:
  - Reset in WAIT or RESP drops the response: no ready is issued.
  - A store accepted before the reset remains committed.
- The address space maps fully onto memory; there is no out-of-range case.
- Reading a never-written word returns X in simulation. The bench must initialise before checking.

Test Plan:
1. Word store/load, WAIT_STATES=0:
   - Store size=10, addr=0x010, wdata=0xDEADBEEF.
   - Then load size=10, addr=0x010.
   - Expect ready at T+1 for each access, rdata=0xDEADBEEF, err=0.
2. Byte lanes and extension:
   - Store word 0x00000000 at 0x020, then store byte 0x80 at 0x022.
   - Load byte signed at 0x022 gives 0xFFFFFF80. Load byte unsigned gives 0x00000080.
   - Load word at 0x020 gives 0x00800000.
3. Half store/load:
   - Store half 0x8001 at 0x032 onto a prior word 0x11111111.
   - Word load gives 0x80011111.
   - Half signed load at 0x032 gives 0xFFFF8001. Half unsigned load gives 0x00008001.
4. Faults:
   - Word store at 0x041 gives err=1, rdata=0.
   - A following word load at 0x040 shows memory unchanged.
   - Half at 0x043 gives err=1. size=11 gives err=1.
5. Wait states and handshake, WAIT_STATES=3:
   - Accept at edge T gives ready only in cycle T+4.
   - req held high throughout is re-accepted only in the IDLE cycle after RESP.
   - Exactly one ready pulse per accepted access.
6. Reset mid-operation, WAIT_STATES=3:
   - Store 0xCAFEF00D at 0x050, assert rst_n=0 during WAIT.
   - Expect no ready, and ready=err=rdata=0 after reset.
   - A subsequent word load at 0x050 returns 0xCAFEF00D.
